// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, word and
// counter widths, and the request legality check (alignment, range, RO window).
package data_mem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dm_state_e;

    // Direction (exactly one of rd/wd) is checked by the caller; this covers
    // the address side. Offsets are widened to 33 bits so the range test
    // cannot wrap for large memories.
    function automatic logic dm_addr_legal(
        input logic [31:0] addr,
        input logic        is_wr,
        input logic [31:0] base,
        input int unsigned mem_words,
        input int unsigned ro_words,
        input logic        ro_en
    );
        logic [32:0] off;
        logic [32:0] span;
        logic [32:0] ro_span;
        off     = {1'b0, addr} - {1'b0, base};
        span    = 33'(mem_words) << 2;
        ro_span = 33'(ro_words) << 2;
        dm_addr_legal = (addr[1:0] == 2'b00) && (addr >= base) && (off < span)
                        && !(ro_en && is_wr && (off < ro_span));
    endfunction

endpackage

// File: rtl/dm_ram_sp.sv
// Synchronous single-port word RAM with registered read data (read-first).
module dm_ram_sp
    import data_mem_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the MMU data port (rd/wd with wait/segv handshake).
// Define DATA_MEM_RO_WINDOW_EN to make the first RO_WORDS words read-only.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2,
    parameter int unsigned RO_WORDS  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              rd,
    input  logic              wd,
    output logic [WORD_W-1:0] rdata,
    output logic              wait_o,
    output logic              segv
);

    localparam int IDX_W = $clog2(MEM_WORDS);
`ifdef DATA_MEM_RO_WINDOW_EN
    localparam logic RO_EN = 1'b1;
`else
    localparam logic RO_EN = 1'b0;
`endif

    dm_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_hold;
    logic [WORD_W-1:0] ram_q;

    logic              req;
    logic              legal;
    logic              accept;
    logic [31:0]       off;
    logic [IDX_W-1:0]  live_idx;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;

    assign req      = rd | wd;
    assign legal    = (rd ^ wd)
                      && dm_addr_legal(addr, wd, BASE_ADDR, MEM_WORDS, RO_WORDS, RO_EN);
    assign accept   = (state == IDLE) && req && legal;
    assign off      = addr - BASE_ADDR;
    assign live_idx = IDX_W'(off >> 2);

    // The RAM reads every cycle; in IDLE it follows the live address so a
    // LATENCY=1 load has its data registered by the completion cycle.
    assign ram_idx  = (state == IDLE) ? live_idx : idx_q;
    assign ram_we   = (state == DONE) && wr_q;

    // rst_n gates the handshake so outputs drop the moment reset is asserted.
    assign wait_o = rst_n && (accept || (state == BUSY));
    assign segv   = rst_n && (state == IDLE) && req && !legal;
    assign rdata  = ((state == DONE) && !wr_q) ? ram_q : rdata_hold;

    dm_ram_sp #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            rdata_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q  <= wd;
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= (LATENCY > 1) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt <= CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!wr_q) begin
                        rdata_hold <= ram_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Captured request payload; only meaningful while a transaction is open.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= live_idx;
            wdata_q <= wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder, plus a LATENCY=1 instance.
module tb_data_mem_responder;

    localparam int          LAT  = 2;
    localparam int          MEMW = 1024;
    localparam int          ROW  = 64;
`ifdef DATA_MEM_RO_WINDOW_EN
    localparam bit          RO_EN = 1'b1;
    localparam logic [31:0] OFFS  = 32'h100;
`else
    localparam bit          RO_EN = 1'b0;
    localparam logic [31:0] OFFS  = 32'h0;
`endif

    typedef struct {
        int          cyc;
        bit          is_load;
        bit          known;
        logic [31:0] data;
    } comp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata;
    logic        rd, wd, wait_o, segv;

    logic [31:0] addr1, wdata1, rdata1;
    logic        rd1, wd1, wait1, segv1;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fails = 0;

    comp_t       exp_q[$];
    bit          exp_wait [int];
    bit          exp_segv [int];
    logic [31:0] mdl [int];

    data_mem_responder #(
        .MEM_WORDS (MEMW),
        .BASE_ADDR (32'h0),
        .LATENCY   (LAT),
        .RO_WORDS  (ROW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .wdata  (wdata),
        .rd     (rd),
        .wd     (wd),
        .rdata  (rdata),
        .wait_o (wait_o),
        .segv   (segv)
    );

    data_mem_responder #(
        .MEM_WORDS (64),
        .BASE_ADDR (32'h0),
        .LATENCY   (1),
        .RO_WORDS  (0)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr1),
        .wdata  (wdata1),
        .rd     (rd1),
        .wd     (wd1),
        .rdata  (rdata1),
        .wait_o (wait1),
        .segv   (segv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got 0x%08h, required 0x%08h", name, cyc, act, req_v);
        end
    endtask

    function automatic bit mdl_legal(input bit r, input bit w, input logic [31:0] a);
        if (r == w) return 1'b0;
        if (a % 4 != 0) return 1'b0;
        if (a >= MEMW * 4) return 1'b0;
        if (RO_EN && w && (a / 4 < ROW)) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one request starting at the next clock; legal requests are held
    // through their completion cycle, illegal ones for their single segv cycle.
    task automatic issue(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit abort_it);
        bit    leg;
        int    wi;
        comp_t c;
        @(posedge clk); #1;
        leg = mdl_legal(r, w, a);
        wi  = int'(a / 4);
        rd = r; wd = w; addr = a; wdata = d;
        if (!leg) begin
            exp_segv[cyc] = 1'b1;
        end else if (abort_it && LAT > 1) begin
            exp_wait[cyc]     = 1'b1;
            exp_wait[cyc + 1] = 1'b1;
            @(posedge clk); #1;
            rd = 1'b0; wd = 1'b0;
        end else begin
            for (int i = 0; i < LAT; i++) exp_wait[cyc + i] = 1'b1;
            c.cyc     = cyc + LAT;
            c.is_load = r;
            c.known   = 1'b1;
            c.data    = 32'h0;
            if (r) begin
                c.known = mdl.exists(wi);
                if (c.known) c.data = mdl[wi];
            end else begin
                mdl[wi] = d;
            end
            exp_q.push_back(c);
            for (int i = 1; i < LAT; i++) begin
                @(posedge clk); #1;
                addr = $urandom; wdata = $urandom;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rd = 1'b0; wd = 1'b0;
        end
    endtask

    // Monitor: per-cycle handshake against the expected waveform, completions
    // against the scoreboard queue, and held rdata in every other cycle.
    initial begin
        bit          prev_wait;
        bit          hold_known;
        logic [31:0] hold;
        bit          ew, es;
        comp_t       c;
        prev_wait  = 1'b0;
        hold_known = 1'b1;
        hold       = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wait  = 1'b0;
                hold_known = 1'b1;
                hold       = 32'h0;
            end else begin
                ew = exp_wait.exists(cyc) ? exp_wait[cyc] : 1'b0;
                es = exp_segv.exists(cyc) ? exp_segv[cyc] : 1'b0;
                check("wait_o", {31'h0, wait_o}, {31'h0, ew});
                check("segv", {31'h0, segv}, {31'h0, es});
                if (prev_wait && !wait_o && (rd | wd) && !segv) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL completion at cycle %0d: got a completion, required none", cyc);
                    end else begin
                        c = exp_q.pop_front();
                        check("done_cycle", cyc, c.cyc);
                        if (c.is_load) begin
                            if (c.known) begin
                                check("rdata_load", rdata, c.data);
                                hold       = c.data;
                                hold_known = 1'b1;
                            end else begin
                                hold_known = 1'b0;
                            end
                        end else if (hold_known) begin
                            check("rdata_hold", rdata, hold);
                        end
                    end
                end else if (hold_known) begin
                    check("rdata_hold", rdata, hold);
                end
                prev_wait = wait_o;
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        bit          r, w, ab;
        int          sel;

        rst_n = 1'b0;
        rd = 1'b0; wd = 1'b0; addr = 32'h0; wdata = 32'h0;
        rd1 = 1'b0; wd1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wait", {31'h0, wait_o}, 32'h0);
        check("reset_segv", {31'h0, segv}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_rdata1", rdata1, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Preload directed words and the random pool.
        issue(1'b0, 1'b1, 32'h20 + OFFS, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h40 + OFFS, 32'h1111_2222, 1'b0);
        for (int i = 64; i < 80; i++) issue(1'b0, 1'b1, i * 4, $urandom, 1'b0);
        for (int i = MEMW - 4; i < MEMW; i++) issue(1'b0, 1'b1, i * 4, $urandom, 1'b0);
        idle(1);

        // Store then load of one word, with a gap and then back-to-back.
        issue(1'b0, 1'b1, 32'h10 + OFFS, 32'hDEAD_BEEF, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 32'h10 + OFFS, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h40 + OFFS, 32'h0, 1'b0);
        idle(1);

        // Illegal requests: misaligned, past the end, and both rd and wd.
        issue(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(1'b1, 1'b0, MEMW * 4, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 32'h0, 32'h5555_5555, 1'b0);
        issue(1'b1, 1'b1, 32'h40 + OFFS, 32'h6666_6666, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 32'h40 + OFFS, 32'h0, 1'b0);
        idle(1);

        // Store abandoned in its BUSY cycle must not land.
        issue(1'b0, 1'b1, 32'h20 + OFFS, 32'h0000_1234, 1'b1);
        idle(2);
        issue(1'b1, 1'b0, 32'h20 + OFFS, 32'h0, 1'b0);
        idle(1);

        // Reset pulse during the BUSY cycle of a store.
        @(posedge clk); #1;
        rd = 1'b0; wd = 1'b1; addr = 32'h40 + OFFS; wdata = 32'hBAD0_BAD0;
        exp_wait[cyc] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; wd = 1'b0;
        #1;
        check("rst_mid_wait", {31'h0, wait_o}, 32'h0);
        check("rst_mid_segv", {31'h0, segv}, 32'h0);
        check("rst_mid_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        issue(1'b1, 1'b0, 32'h40 + OFFS, 32'h0, 1'b0);
        idle(1);

        // Read-only window boundary.
        issue(1'b0, 1'b1, 32'h0FC, 32'h0F0F_0F0F, 1'b0);
        idle(1);
        issue(1'b0, 1'b1, 32'h100, 32'hCAFE_0100, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 32'h0FC, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        idle(1);

        // Random mix over the preloaded pool.
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 99);
            a   = (sel < 80) ? 32'($urandom_range(64, 79) * 4)
                             : 32'($urandom_range(MEMW - 4, MEMW - 1) * 4);
            r   = $urandom_range(0, 1) == 1;
            w   = !r;
            sel = $urandom_range(0, 99);
            if (sel < 8)       begin r = 1'b1; w = 1'b1; end
            else if (sel < 16) a = a | 32'($urandom_range(1, 3));
            else if (sel < 22) a = 32'(MEMW * 4 + $urandom_range(0, 7) * 4);
            d  = $urandom;
            ab = $urandom_range(0, 9) == 0;
            issue(r, w, a, d, ab);
            idle($urandom_range(0, 2));
        end
        idle(4);
        check("queue_empty", exp_q.size(), 32'h0);

        // LATENCY=1 instance: store then back-to-back load of the same word.
        @(posedge clk); #1;
        wd1 = 1'b1; addr1 = 32'h8; wdata1 = 32'hA5A5_A5A5;
        @(negedge clk);
        check("l1_wr_wait", {31'h0, wait1}, 32'h1);
        check("l1_wr_segv", {31'h0, segv1}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_wr_done", {31'h0, wait1}, 32'h0);
        @(posedge clk); #1;
        wd1 = 1'b0; rd1 = 1'b1; wdata1 = 32'h0;
        @(negedge clk);
        check("l1_rd_wait", {31'h0, wait1}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_rd_done", {31'h0, wait1}, 32'h0);
        check("l1_rdata", rdata1, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        rd1 = 1'b0;
        @(negedge clk);
        check("l1_rdata_hold", rdata1, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 32'h100;
        @(negedge clk);
        check("l1_oob_segv", {31'h0, segv1}, 32'h1);
        check("l1_oob_wait", {31'h0, wait1}, 32'h0);
        @(posedge clk); #1;
        rd1 = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
